ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 28000000, clk_sys frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 100, clock-inhibit duration in microseconds.
REQ-003 Parameter TIMEOUT_MS, default 15, maximum transfer time from clock release to ack.
REQ-004 Parameter FILT_LEN, default 8, consecutive equal samples needed to accept a line level.
REQ-005 clk_sys  input  1  system clock, all logic on its rising edge.
REQ-006 nRESET  input  1  reset, synchronous, active-low.
REQ-007 tx_data  input  8  byte to send to the device (0xFF reset, 0xED set LEDs, ...).
REQ-008 tx_valid  input  1  request; the byte is accepted in a cycle with tx_valid=1 and tx_ready=1.
REQ-009 tx_ready  output  1  high only in IDLE.
REQ-010 tx_done  output  1  one-cycle pulse when the device acks and the bus returns idle.
REQ-011 tx_error  output  1  one-cycle pulse on timeout or missing ack.
REQ-012 busy  output  1  high in every state except IDLE; the PS/2 receiver ignores the bus while busy=1.
REQ-013 ps2_clk_in, ps2_dat_in  input  1 each  raw PS/2 line levels (asynchronous).
REQ-014 ps2_clk_oe, ps2_dat_oe  output  1 each  open-drain pull-low enables; 1 drives the line low, 0 releases it.

Function
REQ-015 Both raw line inputs SHALL pass through a 2-flop synchronizer and then a FILT_LEN-sample stability filter; "falling edge" means the filtered clock going from 1 to 0.
REQ-016 States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: on acceptance, latch tx_data, compute odd parity (parity = ~^tx_data), then go to INHIBIT; clk_oe=0 and dat_oe=0.
REQ-018 INHIBIT: clk_oe=1 for exactly CLK_HZ*INHIBIT_US/1e6 cycles (2800 at defaults), then go to RTS.
REQ-019 RTS: dat_oe=1 (start bit) with clk_oe held for 16 cycles, then release clk_oe, start the timeout counter and go to SHIFT.
REQ-020 SHIFT: on falling edge k = 1..8 dat_oe = ~data[k-1] (LSB first); k=9 dat_oe = ~parity; k=10 dat_oe=0 (stop bit); after edge 10 go to ACK.
REQ-021 ACK: on the next falling edge, sample filtered data; 0 -> WAIT_IDLE, 1 -> tx_error pulse and IDLE.
REQ-022 WAIT_IDLE: when filtered clock and data are both 1, pulse tx_done and go to IDLE.
REQ-023 The timeout counter SHALL count cycles in SHIFT, ACK and WAIT_IDLE; reaching CLK_HZ/1000*TIMEOUT_MS (420000 at defaults, 19-bit counter) forces both OE to 0, pulses tx_error and returns to IDLE.
REQ-024 tx_done and tx_error SHALL never assert in the same cycle; timeout takes priority over a coincident edge.
REQ-025 tx_valid while not ready SHALL be ignored; the latched byte is stable for the whole transfer.
REQ-026 The bit counter SHALL be 4 bits, cleared on entry to SHIFT, and never wrap past 10.
REQ-027 Device clocking seen in IDLE or INHIBIT SHALL have no effect on state.

Reset
REQ-028 While nRESET=0 at a clk_sys edge: state IDLE, clk_oe=0, dat_oe=0, tx_ready=0, busy=0, tx_done=0, tx_error=0, counters 0, filters set to 1.
REQ-029 tx_ready SHALL assert on the first cycle after nRESET returns to 1.
REQ-030 Reset mid-transfer SHALL release both lines in the cycle it is sampled, with no done or error pulse.

Structure
REQ-031 A shared package ps2_pkg SHALL hold the state enum, PS2_FRAME_BITS=10 and the command constants 0xFF, 0xED and 0xF4.
REQ-032 The synchronizer and filter SHALL be a sub-module ps2_line_filter, instantiated once for the clock line and once for the data line.

Verification
REQ-033 Send 0x01 with a device model clocking at 12.5 kHz and acking: clk_oe is low for 2800 cycles; data bits 1,0,0,0,0,0,0,0; parity 0; stop 1; one tx_done pulse.
REQ-034 Send 0xED: parity bit 1 on edge 9; tx_done pulses; tx_ready returns to 1.
REQ-035 Device never clocks: tx_error pulses 420000 cycles after clock release; both OE=0.
REQ-036 Device leaves data high at the ack edge: tx_error pulses and there is no tx_done.
REQ-037 nRESET=0 after edge 5: next cycle OE=0 and state IDLE; a new send of 0xFF then completes normally.
REQ-038 1-cycle glitches on ps2_clk_in during SHIFT: the bit count is unchanged and the frame is correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam int PS2_FRAME_BITS = 10;
    localparam int PS2_RTS_CYCLES = 16;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one raw PS/2 line.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_sys,
    input  logic nRESET,
    input  logic line_raw,
    output logic line_filt
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] run_cnt;

    // The filtered level only follows the line after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            run_cnt   <= '0;
            line_filt <= 1'b1;
        end else begin
            sync_a <= line_raw;
            sync_b <= sync_a;
            if (sync_b == line_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILT_LEN - 1)) begin
                line_filt <= sync_b;
                run_cnt   <= '0;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibits the bus, requests to send, then shifts one byte
// out on device-generated clock falling edges and checks the device ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 28000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15,
    parameter int FILT_LEN   = 8
) (
    input  logic       clk_sys,
    input  logic       nRESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam longint INHIBIT_L   = longint'(CLK_HZ) * longint'(INHIBIT_US) / 64'sd1000000;
    localparam int     INHIBIT_CYC = int'(INHIBIT_L);
    localparam int     TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int     PH_W = $clog2(INHIBIT_CYC > PS2_RTS_CYCLES ? INHIBIT_CYC : PS2_RTS_CYCLES);
    localparam int     TO_W = $clog2(TIMEOUT_CYC);

    ps2_tx_state_t state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [TO_W-1:0] to_q, to_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          ready_en_q;
    logic          clk_filt, dat_filt, clk_filt_q;
    logic          clk_fall;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filter (
        .clk_sys   (clk_sys),
        .nRESET    (nRESET),
        .line_raw  (ps2_clk_in),
        .line_filt (clk_filt)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filter (
        .clk_sys   (clk_sys),
        .nRESET    (nRESET),
        .line_raw  (ps2_dat_in),
        .line_filt (dat_filt)
    );

    assign clk_fall   = clk_filt_q & ~clk_filt;
    assign tx_ready   = (state_q == ST_IDLE) && ready_en_q;
    assign busy       = (state_q != ST_IDLE);
    assign ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
    assign ps2_dat_oe = dat_oe_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;

    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            phase_q    <= '0;
            to_q       <= '0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ready_en_q <= 1'b0;
            clk_filt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            to_q       <= to_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ready_en_q <= 1'b1;
            clk_filt_q <= clk_filt;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        to_d      = to_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dat_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    data_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    phase_d  = '0;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (phase_q == PH_W'(INHIBIT_CYC - 1)) begin
                    phase_d  = '0;
                    dat_oe_d = 1'b1;
                    state_d  = ST_RTS;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_RTS: begin
                if (phase_q == PH_W'(PS2_RTS_CYCLES - 1)) begin
                    phase_d   = '0;
                    to_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_SHIFT: begin
                // bit_cnt_q holds the number of falling edges already consumed
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                    end else if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (!dat_filt) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_filt && dat_filt) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Timeout overrides whatever the device did in the same cycle.
        if (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
            if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                state_d  = ST_IDLE;
                dat_oe_d = 1'b0;
                done_d   = 1'b0;
                error_d  = 1'b1;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ      = 2000000;
    localparam int INHIBIT_US  = 100;
    localparam int TIMEOUT_MS  = 2;
    localparam int FILT_LEN    = 8;
    localparam int EXP_INHIBIT = CLK_HZ / 1000000 * INHIBIT_US;
    localparam int EXP_TIMEOUT = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int HALF        = CLK_HZ / 12500 / 2;

    logic       clk_sys = 1'b0;
    logic       nRESET = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    int total = 0;
    int bad = 0;
    int done_total = 0;
    int err_total = 0;
    int overlap_total = 0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_MS(TIMEOUT_MS), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk_sys    (clk_sys),
        .nRESET     (nRESET),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (tx_done === 1'b1) done_total++;
        if (tx_error === 1'b1) err_total++;
        if (tx_done === 1'b1 && tx_error === 1'b1) overlap_total++;
    end

    // Line-level frame the device should see: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL send_ready: tx_ready=%b required 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_sys);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Counts inhibit and RTS cycles while spamming tx_valid with junk bytes.
    task automatic wait_release(output int inh, output int rts);
        int n = 0;
        inh = 0;
        rts = 0;
        while (ps2_clk_oe === 1'b1 && n < 20000) begin
            if (ps2_dat_oe === 1'b1) rts++;
            else inh++;
            tx_valid = (ps2_dat_oe === 1'b0);
            tx_data  = 8'($urandom);
            @(negedge clk_sys);
            n++;
        end
        tx_valid = 1'b0;
    endtask

    // Device clocks edges 1..last_edge; a partial frame returns with the clock held low.
    task automatic device_clock(input bit ack, input bit glitch, input int last_edge,
                                output logic [9:0] bits);
        bits = '0;
        settle(20);
        for (int k = 1; k <= last_edge; k++) begin
            if (k == 11 && ack) begin
                dev_dat = 1'b0;
                settle(HALF / 2);
            end
            dev_clk = 1'b0;
            settle(HALF);
            if (k == last_edge && last_edge < 11) return;
            if (k <= 10) bits[k-1] = ps2_dat_in;
            for (int h = 0; h < HALF; h++) begin
                dev_clk = (glitch && h == HALF / 2) ? 1'b0 : 1'b1;
                @(negedge clk_sys);
            end
        end
        dev_dat = 1'b1;
    endtask

    task automatic test_reset();
        settle(3);
        total++;
        if ({tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b required 000000",
                     {tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
        end
        nRESET = 1'b1;
        @(negedge clk_sys);
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_ready: tx_ready=%b required 1", tx_ready);
        end
    endtask

    task automatic test_idle_clocking();
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0;
            settle(HALF);
            dev_clk = 1'b1;
            settle(HALF);
        end
        total++;
        if ({busy, tx_ready, ps2_clk_oe, ps2_dat_oe} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL idle_clocking: got %b required 0100",
                     {busy, tx_ready, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_send(input logic [7:0] d, input bit glitch, input string name);
        logic [9:0] bits;
        int inh, rts, d0, e0;
        d0 = done_total;
        e0 = err_total;
        send_byte(d);
        wait_release(inh, rts);
        total++;
        if (inh !== EXP_INHIBIT) begin
            bad++;
            $display("[TB] FAIL %s_inhibit: got %0d cycles required %0d", name, inh, EXP_INHIBIT);
        end
        total++;
        if (rts !== PS2_RTS_CYCLES) begin
            bad++;
            $display("[TB] FAIL %s_rts: got %0d cycles required %0d", name, rts, PS2_RTS_CYCLES);
        end
        total++;
        if (ps2_dat_oe !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_start_bit: dat_oe=%b required 1", name, ps2_dat_oe);
        end
        device_clock(1'b1, glitch, 11, bits);
        settle(100);
        total++;
        if (bits !== frame_of(d)) begin
            bad++;
            $display("[TB] FAIL %s_frame: got %b required %b", name, bits, frame_of(d));
        end
        total++;
        if (done_total - d0 !== 1 || err_total - e0 !== 0) begin
            bad++;
            $display("[TB] FAIL %s_pulses: done=%0d error=%0d required 1/0",
                     name, done_total - d0, err_total - e0);
        end
        total++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_ready_after: ready=%b busy=%b required 1/0", name, tx_ready, busy);
        end
    endtask

    task automatic test_parity_ed();
        logic [9:0] bits;
        int inh, rts;
        send_byte(PS2_CMD_SET_LEDS);
        wait_release(inh, rts);
        device_clock(1'b1, 1'b0, 11, bits);
        settle(100);
        total++;
        if (bits[8] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ed_parity: got %b required 1", bits[8]);
        end
    endtask

    task automatic test_timeout();
        int inh, rts, n, e0;
        e0 = err_total;
        send_byte(8'($urandom));
        wait_release(inh, rts);
        n = 0;
        while (tx_error !== 1'b1 && n < 2 * EXP_TIMEOUT) begin
            @(negedge clk_sys);
            n++;
        end
        total++;
        if (n !== EXP_TIMEOUT) begin
            bad++;
            $display("[TB] FAIL timeout_latency: got %0d cycles required %0d", n, EXP_TIMEOUT);
        end
        total++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL timeout_release: got %b required 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        settle(5);
        total++;
        if (err_total - e0 !== 1) begin
            bad++;
            $display("[TB] FAIL timeout_pulse: got %0d error pulses required 1", err_total - e0);
        end
    endtask

    task automatic test_nack();
        logic [7:0] d;
        logic [9:0] bits;
        int inh, rts, d0, e0;
        d = 8'($urandom);
        d0 = done_total;
        e0 = err_total;
        send_byte(d);
        wait_release(inh, rts);
        device_clock(1'b0, 1'b0, 11, bits);
        settle(100);
        total++;
        if (done_total - d0 !== 0 || err_total - e0 !== 1) begin
            bad++;
            $display("[TB] FAIL nack_pulses: done=%0d error=%0d required 0/1",
                     done_total - d0, err_total - e0);
        end
        total++;
        if (bits !== frame_of(d)) begin
            bad++;
            $display("[TB] FAIL nack_frame: got %b required %b", bits, frame_of(d));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        int inh, rts, d0, e0;
        d0 = done_total;
        e0 = err_total;
        send_byte(8'($urandom));
        wait_release(inh, rts);
        device_clock(1'b1, 1'b0, 5, bits);
        nRESET = 1'b0;
        @(negedge clk_sys);
        total++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, tx_ready} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL midreset_release: got %b required 0000",
                     {ps2_clk_oe, ps2_dat_oe, busy, tx_ready});
        end
        nRESET = 1'b1;
        @(negedge clk_sys);
        dev_clk = 1'b1;
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_ready: tx_ready=%b required 1", tx_ready);
        end
        settle(50);
        total++;
        if (done_total - d0 !== 0 || err_total - e0 !== 0) begin
            bad++;
            $display("[TB] FAIL midreset_pulses: done=%0d error=%0d required 0/0",
                     done_total - d0, err_total - e0);
        end
        test_send(PS2_CMD_RESET, 1'b0, "after_reset_ff");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            test_send(8'($urandom), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_exclusive();
        total++;
        if (overlap_total !== 0) begin
            bad++;
            $display("[TB] FAIL done_error_overlap: got %0d cycles required 0", overlap_total);
        end
    endtask

    initial begin
        test_reset();
        test_idle_clocking();
        test_send(8'h01, 1'b0, "send_01");
        test_parity_ed();
        test_send(PS2_CMD_SET_LEDS, 1'b0, "send_ed");
        test_timeout();
        test_nack();
        test_reset_mid_frame();
        test_send(PS2_CMD_ENABLE, 1'b1, "glitch_f4");
        test_random();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
